// File: rtl/booth_mult_sequencer.sv
// Sequences a shared combinational 8x8 multiplier over four byte passes to form
// a 16x16 unsigned product, with valid/ready handshakes on operands and result.
module booth_mult_sequencer #(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] P,
   output logic        M_EN,
   output logic [7:0]  M_A,
   output logic [7:0]  M_B,
   input  logic [15:0] M_P,
   output logic        busy
);

   localparam int unsigned OP_W   = 16;
   localparam int unsigned P_W    = 32;
   localparam int unsigned STEP_W = 2;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [STEP_W-1:0]   step;
   logic [OP_W-1:0]     a_reg;
   logic [OP_W-1:0]     b_reg;
   logic [P_W-1:0]      acc;
   logic [P_W-1:0]      term;
   logic [P_W-1:0]      sum;
   logic                accept;
   logic                zero_op;

   assign accept  = in_valid & in_ready;
   assign zero_op = ZERO_SKIP && ((A == '0) || (B == '0));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = zero_op ? DONE : MUL;
         MUL:     if (step == STEP_W'(3)) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs; operand bytes stay at zero outside MUL to keep the adder tree quiet
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      M_EN     = 1'b0;
      M_A      = '0;
      M_B      = '0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         MUL: begin
            M_EN = 1'b1;
            M_A  = step[1] ? a_reg[15:8] : a_reg[7:0];
            M_B  = step[0] ? b_reg[15:8] : b_reg[7:0];
         end
         default: ;
      endcase
   end

   // Partial product weighted by the byte positions of this pass
   always_comb begin
      term = P_W'(M_P);
      unique case (step)
         STEP_W'(0): term = P_W'(M_P);
         STEP_W'(3): term = P_W'(M_P) << 16;
         default:    term = P_W'(M_P) << 8;
      endcase
      sum = acc + term;
   end

   // Operand capture, accumulation and result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step      <= '0;
         acc       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         P         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_next == DONE);
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= A;
                  b_reg <= B;
                  acc   <= '0;
                  step  <= '0;
                  if (zero_op) P <= '0;
               end
            end
            MUL: begin
               acc  <= sum;
               step <= step + STEP_W'(1);
               if (step == STEP_W'(3)) P <= sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Randomized self-checking bench for booth_mult_sequencer; runs a ZERO_SKIP=1 and
// a ZERO_SKIP=0 instance side by side, each with its own behavioural 8x8 multiplier.
module tb_booth_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   logic        in_ready1, out_valid1, m_en1, busy1;
   logic [31:0] p1;
   logic [7:0]  m_a1, m_b1;
   logic [15:0] m_p1;
   logic        in_ready0, out_valid0, m_en0, busy0;
   logic [31:0] p0;
   logic [7:0]  m_a0, m_b0;
   logic [15:0] m_p0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign m_p1 = 16'(m_a1) * 16'(m_b1);
   assign m_p0 = 16'(m_a0) * 16'(m_b0);

   booth_mult_sequencer #(.ZERO_SKIP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .A(a), .B(b), .out_valid(out_valid1), .out_ready(out_ready), .P(p1),
      .M_EN(m_en1), .M_A(m_a1), .M_B(m_b1), .M_P(m_p1), .busy(busy1));

   booth_mult_sequencer #(.ZERO_SKIP(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .A(a), .B(b), .out_valid(out_valid0), .out_ready(out_ready), .P(p0),
      .M_EN(m_en0), .M_A(m_a0), .M_B(m_b0), .M_P(m_p0), .busy(busy0));

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // Expected {in_ready, out_valid, busy, M_EN, M_A, M_B} c cycles after accept,
   // result appearing at cycle lat and consumed immediately
   function automatic logic [19:0] exp_ctl(input int lat, input int c,
                                           input logic [15:0] ta, input logic [15:0] tb_);
      logic [7:0] ea, eb;
      logic       en;
      ea = 8'h00;
      eb = 8'h00;
      en = 1'b0;
      if (c < lat) begin
         en = 1'b1;
         ea = ((c - 1) / 2 == 1) ? ta[15:8] : ta[7:0];
         eb = ((c - 1) % 2 == 1) ? tb_[15:8] : tb_[7:0];
      end
      return {c > lat, c == lat, c <= lat, en, ea, eb};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      step_clk();
      step_clk();
      vectors++;
      if ({in_ready1, out_valid1, busy1, m_en1, m_a1, m_b1, p1} !== {4'b1000, 16'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_zs1: got rdy=%b ov=%b busy=%b en=%b ma=%h mb=%h p=%h expected 1 0 0 0 00 00 00000000",
                  in_ready1, out_valid1, busy1, m_en1, m_a1, m_b1, p1);
      end
      vectors++;
      if ({in_ready0, out_valid0, busy0, m_en0, m_a0, m_b0, p0} !== {4'b1000, 16'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_zs0: got rdy=%b ov=%b busy=%b en=%b ma=%h mb=%h p=%h expected 1 0 0 0 00 00 00000000",
                  in_ready0, out_valid0, busy0, m_en0, m_a0, m_b0, p0);
      end
      rst_n = 1'b1;
      step_clk();
   endtask

   // One job with out_ready held high; checks both instances cycle by cycle
   task automatic test_job(input logic [15:0] ta, input logic [15:0] tb_);
      int          lat1;
      logic [31:0] exp_p;
      logic [19:0] e;
      exp_p = 32'(ta) * 32'(tb_);
      lat1 = (ta == 16'h0 || tb_ == 16'h0) ? 1 : 5;
      a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
      step_clk();
      in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         e = exp_ctl(lat1, c, ta, tb_);
         vectors++;
         if ({in_ready1, out_valid1, busy1, m_en1, m_a1, m_b1} !== e) begin
            miscompares++;
            $display("FAIL job_ctl_zs1 a=%h b=%h cyc=%0d: got %h expected %h", ta, tb_, c,
                     {in_ready1, out_valid1, busy1, m_en1, m_a1, m_b1}, e);
         end
         e = exp_ctl(5, c, ta, tb_);
         vectors++;
         if ({in_ready0, out_valid0, busy0, m_en0, m_a0, m_b0} !== e) begin
            miscompares++;
            $display("FAIL job_ctl_zs0 a=%h b=%h cyc=%0d: got %h expected %h", ta, tb_, c,
                     {in_ready0, out_valid0, busy0, m_en0, m_a0, m_b0}, e);
         end
         if (c == lat1) begin
            vectors++;
            if (p1 !== exp_p) begin
               miscompares++;
               $display("FAIL job_p_zs1 a=%h b=%h: got %h expected %h", ta, tb_, p1, exp_p);
            end
         end
         if (c == 5) begin
            vectors++;
            if (p0 !== exp_p) begin
               miscompares++;
               $display("FAIL job_p_zs0 a=%h b=%h: got %h expected %h", ta, tb_, p0, exp_p);
            end
         end
         if (c < 6) step_clk();
      end
   endtask

   task automatic test_directed();
      test_job(16'h1234, 16'h5678);
      test_job(16'hFFFF, 16'hFFFF);
      test_job(16'h0001, 16'h0001);
      test_job(16'h0000, 16'hABCD);
      test_job(16'hABCD, 16'h0000);
   endtask

   task automatic test_random();
      logic [15:0] ra, rb;
      for (int i = 0; i < 20; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         test_job(ra, rb);
      end
   endtask

   task automatic test_backpressure();
      int found;
      found = -1;
      a = 16'h00FF; b = 16'h0100; in_valid = 1'b1; out_ready = 1'b0;
      step_clk();
      in_valid = 1'b0;
      for (int c = 1; c <= 10 && found < 0; c++) begin
         if (out_valid1 === 1'b1) found = c;
         else step_clk();
      end
      vectors++;
      if (found != 5) begin
         miscompares++;
         $display("FAIL bp_latency: got %0d expected 5", found);
      end
      for (int h = 0; h < 4; h++) begin
         if (h == 0) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h0002;
         end else begin
            in_valid = 1'b0;
         end
         if (h == 3) out_ready = 1'b1;
         vectors++;
         if ({out_valid1, in_ready1, p1, out_valid0, in_ready0, p0} !==
             {2'b10, 32'h0000FF00, 2'b10, 32'h0000FF00}) begin
            miscompares++;
            $display("FAIL bp_hold h=%0d: got ov=%b rdy=%b p=%h / ov=%b rdy=%b p=%h expected ov=1 rdy=0 p=0000ff00",
                     h, out_valid1, in_ready1, p1, out_valid0, in_ready0, p0);
         end
         step_clk();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         vectors++;
         if ({out_valid1, in_ready1, m_en1, p1, out_valid0, in_ready0, m_en0} !==
             {3'b010, 32'h0000FF00, 3'b010}) begin
            miscompares++;
            $display("FAIL bp_release c=%0d: got ov=%b rdy=%b en=%b p=%h / ov=%b rdy=%b en=%b expected ov=0 rdy=1 en=0 p=0000ff00",
                     c, out_valid1, in_ready1, m_en1, p1, out_valid0, in_ready0, m_en0);
         end
         step_clk();
      end
   endtask

   task automatic test_reset_mid();
      a = 16'h1234; b = 16'h5678; in_valid = 1'b1; out_ready = 1'b1;
      step_clk();
      in_valid = 1'b0;
      step_clk();
      step_clk();
      vectors++;
      if ({m_en1, m_a1, m_b1} !== {1'b1, 8'h12, 8'h78}) begin
         miscompares++;
         $display("FAIL mid_step2: got en=%b ma=%h mb=%h expected 1 12 78", m_en1, m_a1, m_b1);
      end
      rst_n = 1'b0;
      step_clk();
      vectors++;
      if ({in_ready1, out_valid1, m_en1, busy1, in_ready0, out_valid0, m_en0, busy0} !== 8'b1000_1000) begin
         miscompares++;
         $display("FAIL mid_reset: got %b expected 10001000",
                  {in_ready1, out_valid1, m_en1, busy1, in_ready0, out_valid0, m_en0, busy0});
      end
      rst_n = 1'b1;
      test_job(16'h0003, 16'h0005);
   endtask

   task automatic test_back_to_back();
      logic [15:0] ja [3];
      logic [15:0] jb [3];
      logic [31:0] exp_p;
      bit          exp_ov;
      for (int j = 0; j < 3; j++) begin
         ja[j] = 16'($urandom_range(1, 16'hFFFF));
         jb[j] = 16'($urandom_range(1, 16'hFFFF));
      end
      a = ja[0]; b = jb[0]; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         step_clk();
         if (c == 1)  begin a = ja[1]; b = jb[1]; end
         if (c == 7)  begin a = ja[2]; b = jb[2]; end
         if (c == 13) in_valid = 1'b0;
         exp_ov = (c == 5 || c == 11 || c == 17);
         vectors++;
         if ({out_valid1, out_valid0} !== {exp_ov, exp_ov}) begin
            miscompares++;
            $display("FAIL b2b_valid cyc=%0d: got %b%b expected %b", c, out_valid1, out_valid0, exp_ov);
         end
         if (exp_ov) begin
            exp_p = 32'(ja[c / 6]) * 32'(jb[c / 6]);
            vectors++;
            if ({p1, p0} !== {exp_p, exp_p}) begin
               miscompares++;
               $display("FAIL b2b_p cyc=%0d: got %h / %h expected %h", c, p1, p0, exp_p);
            end
         end
      end
      step_clk();
      vectors++;
      if ({in_ready1, out_valid1, in_ready0, out_valid0} !== 4'b1010) begin
         miscompares++;
         $display("FAIL b2b_drain: got %b expected 1010", {in_ready1, out_valid1, in_ready0, out_valid0});
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
